// File: rtl/overlap_add_mc_if.sv
// Stream bundle for overlap_add_mc: sample input, history clear request,
// overlap-added output, and block/saturation status.
interface overlap_add_mc_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 1
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CH_W-1:0]   in_ch;
    logic              clr;
    logic [CH_W-1:0]   clr_ch;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic              frame_done;
    logic              sat_flag;

    modport master (
        output in_valid, in_data, in_ch, clr, clr_ch, out_ready,
        input  in_ready, out_valid, out_data, out_ch, frame_done, sat_flag
    );

    modport slave (
        input  in_valid, in_data, in_ch, clr, clr_ch, out_ready,
        output in_ready, out_valid, out_data, out_ch, frame_done, sat_flag
    );
endinterface

// File: rtl/overlap_add_mc.sv
// Multi-channel IMDCT overlap-add: first half of each block is added to the stored
// history and emitted, second half replaces the history. Define OVERLAP_SAT_EN to clamp sums.
module overlap_add_mc #(
    parameter int DATA_W   = 16,
    parameter int HALF_LEN = 18,
    parameter int CHANNELS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    overlap_add_mc_if.slave bus
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IDX_W = (HALF_LEN > 1) ? $clog2(HALF_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HALF_LEN - 1);

    typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [CH_W-1:0]   cur_ch;
    logic              pend_clr;
    logic [CHANNELS-1:0] hist_vld;
    logic [DATA_W-1:0] hist [CHANNELS][HALF_LEN];

    logic              in_ready;
    logic              accept;
    logic              last;
    logic [CH_W-1:0]   blk_ch;
    logic              clr_hits_blk;
    logic              hist_live;
    logic [DATA_W-1:0] hist_rd;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] result;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [CH_W-1:0]   out_ch_q;
    logic              frame_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE, FIRST: in_ready = !out_valid_q || bus.out_ready;
                SECOND:      in_ready = 1'b1;
                default:     in_ready = 1'b0;
            endcase
        end
        accept = bus.in_valid && in_ready;
        last   = (idx == LAST_IDX);
        if (accept) begin
            case (state)
                IDLE:    state_next = last ? SECOND : FIRST;
                FIRST:   if (last) state_next = SECOND;
                SECOND:  if (last) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // The channel is only taken from in_ch on the first sample; a clear of that
    // same channel in that IDLE cycle must already mask the history read.
    always_comb begin
        blk_ch       = (state == IDLE) ? bus.in_ch : cur_ch;
        clr_hits_blk = bus.clr && (bus.clr_ch == blk_ch);
        hist_live    = hist_vld[blk_ch] && !((state == IDLE) && clr_hits_blk);
        hist_rd      = hist_live ? hist[blk_ch][idx] : '0;
        sum          = {hist_rd[DATA_W-1], hist_rd} + {bus.in_data[DATA_W-1], bus.in_data};
    end

`ifdef OVERLAP_SAT_EN
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic overflow;
    logic sat_q;

    always_comb begin
        overflow = sum[DATA_W] ^ sum[DATA_W-1];
        result   = sum[DATA_W-1:0];
        if (overflow) begin
            result = sum[DATA_W] ? MIN_NEG : MAX_POS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (accept && (state != SECOND) && overflow) begin
            sat_q <= 1'b1;
        end
    end

    assign bus.sat_flag = sat_q;
`else
    logic sum_msb_unused;

    assign result         = sum[DATA_W-1:0];
    assign sum_msb_unused = sum[DATA_W];
    assign bus.sat_flag   = 1'b0;
`endif

    // A clear aimed at the block's own channel is held in pend_clr and wins over
    // the history store at block end; any other clear takes effect immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            cur_ch       <= '0;
            pend_clr     <= 1'b0;
            hist_vld     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                idx <= last ? '0 : idx + 1'b1;
                if (state == IDLE) begin
                    cur_ch <= bus.in_ch;
                end
                if (state != SECOND) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= result;
                    out_ch_q    <= blk_ch;
                end
            end
            if (bus.clr) begin
                if ((state == IDLE) || !clr_hits_blk) begin
                    hist_vld[bus.clr_ch] <= 1'b0;
                end else begin
                    pend_clr <= 1'b1;
                end
            end
            if (accept && (state == SECOND) && last) begin
                hist_vld[cur_ch] <= !(pend_clr || clr_hits_blk);
                pend_clr         <= 1'b0;
                frame_done_q     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && (state == SECOND)) begin
            hist[cur_ch][idx] <= bus.in_data;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_overlap_add_mc.sv
// Testbench for overlap_add_mc (DATA_W=16, HALF_LEN=4, CHANNELS=2) with a block-level
// reference model; honours OVERLAP_SAT_EN when defined for the whole build.
module tb_overlap_add_mc;
    logic clk;
    logic rst_n;

    overlap_add_mc_if #(.DATA_W(16), .CH_W(1)) bus ();

    overlap_add_mc #(.DATA_W(16), .HALF_LEN(4), .CHANNELS(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors = 0;
    int errors  = 0;

    logic [15:0] model_hist [2][4];
    logic        model_vld  [2];
    logic        ref_sat;
    int          exp_fd;
    int          fd_count;
    logic [16:0] exp_q [$];
    logic [16:0] got_q [$];
    logic        rand_bp   = 1'b0;
    logic        rand_gaps = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output collector: a transfer happens at the posedge following this negedge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) got_q.push_back({bus.out_ch, bus.out_data});
        if (rst_n && bus.frame_done) fd_count++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] h);
        int s;
        s = int'($signed(a)) + int'($signed(h));
`ifdef OVERLAP_SAT_EN
        if (s > 32767) begin ref_sat = 1'b1; return 16'h7FFF; end
        if (s < -32768) begin ref_sat = 1'b1; return 16'h8000; end
`endif
        return s[15:0];
    endfunction

    // clr_mode: 0 none, 1 clear of this channel during the block, 2 clear with first sample
    task automatic model_block(input logic ch, input logic [15:0] s[8], input int clr_mode);
        if (clr_mode == 2) model_vld[ch] = 1'b0;
        for (int k = 0; k < 4; k++)
            exp_q.push_back({ch, ref_sum(s[k], model_vld[ch] ? model_hist[ch][k] : 16'h0)});
        for (int k = 0; k < 4; k++) model_hist[ch][k] = s[k+4];
        model_vld[ch] = (clr_mode != 1);
        exp_fd++;
    endtask

    task automatic model_reset();
        model_vld[0] = 1'b0;
        model_vld[1] = 1'b0;
        ref_sat  = 1'b0;
        exp_fd   = 0;
        fd_count = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic drive_sample(input logic [15:0] d, input logic ch);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_ch    = ch;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 200) begin
                vectors++; errors++;
                $display("[TB] FAIL in_ready_timeout got 0 want 1 after %0d cycles", waited);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_block(input logic ch, input logic [15:0] s[8], input int clr_at, input logic cch);
        for (int k = 0; k < 8; k++) begin
            if (rand_gaps && ($urandom_range(0, 3) == 0))
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            if (k == clr_at) begin bus.clr = 1'b1; bus.clr_ch = cch; end
            drive_sample(s[k], (k == 0) ? ch : 1'($urandom));
            bus.clr = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((got_q.size() < exp_q.size()) && (n < 1000)) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ch = '0;
        bus.clr = 1'b0; bus.clr_ch = '0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'h1234; bus.in_ch = '0;
        bus.clr = 1'b0; bus.clr_ch = '0; bus.out_ready = 1'b1;
        @(negedge clk);
        vectors += 6;
        if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready got %b want 0", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got %b want 0", bus.out_valid); end
        if (bus.out_data !== 16'h0) begin errors++; $display("[TB] FAIL rst_out_data got 0x%h want 0x0000", bus.out_data); end
        if (bus.out_ch !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_ch got %b want 0", bus.out_ch); end
        if (bus.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_done got %b want 0", bus.frame_done); end
        if (bus.sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL rst_sat_flag got %b want 0", bus.sat_flag); end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors += 2;
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_in_ready got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_out_valid got %b want 0", bus.out_valid); end
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_basic();
        logic [15:0] s[8];
        logic [16:0] g, e;
        s = '{1, 2, 3, 4, 5, 6, 7, 8};
        model_block(1'b0, s, 0); send_block(1'b0, s, -1, 1'b0);
        s = '{10, 20, 30, 40, 0, 0, 0, 0};
        model_block(1'b0, s, 0); send_block(1'b0, s, -1, 1'b0);
        drain();
        vectors++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (g !== e) begin errors++; $display("[TB] FAIL basic_out got ch%0d 0x%h want ch%0d 0x%h", g[16], g[15:0], e[16], e[15:0]); end
        end
        got_q.delete(); exp_q.delete();
        vectors++;
        if (fd_count != exp_fd) begin errors++; $display("[TB] FAIL basic_frame_done got %0d want %0d", fd_count, exp_fd); end
    endtask

    task automatic test_channels();
        logic [15:0] s[8];
        logic [16:0] g, e;
        s = '{1, 2, 3, 4, 5, 6, 7, 8};
        model_block(1'b0, s, 0); send_block(1'b0, s, -1, 1'b0);
        s = '{100, 101, 102, 103, 104, 105, 106, 107};
        model_block(1'b1, s, 0); send_block(1'b1, s, -1, 1'b0);
        s = '{0, 0, 0, 0, 0, 0, 0, 0};
        model_block(1'b0, s, 0); send_block(1'b0, s, -1, 1'b0);
        drain();
        vectors++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL chan_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (g !== e) begin errors++; $display("[TB] FAIL chan_out got ch%0d 0x%h want ch%0d 0x%h", g[16], g[15:0], e[16], e[15:0]); end
        end
        got_q.delete(); exp_q.delete();
        vectors++;
        if (fd_count != exp_fd) begin errors++; $display("[TB] FAIL chan_frame_done got %0d want %0d", fd_count, exp_fd); end
    endtask

    task automatic test_sat();
        logic [15:0] s[8];
        logic [16:0] g, e;
        s = '{0, 0, 0, 0, 16'h7000, 16'h7000, 16'h7000, 16'h7000};
        model_block(1'b0, s, 0); send_block(1'b0, s, -1, 1'b0);
        s = '{16'h7000, 16'h7000, 16'h7000, 16'h7000, 0, 0, 0, 0};
        model_block(1'b0, s, 0); send_block(1'b0, s, -1, 1'b0);
        drain();
        vectors++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL sat_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (g !== e) begin errors++; $display("[TB] FAIL sat_out got ch%0d 0x%h want ch%0d 0x%h", g[16], g[15:0], e[16], e[15:0]); end
        end
        got_q.delete(); exp_q.delete();
        vectors++;
        if (bus.sat_flag !== ref_sat) begin errors++; $display("[TB] FAIL sat_flag got %b want %b", bus.sat_flag, ref_sat); end
    endtask

    task automatic test_backpressure();
        logic [15:0] s[8];
        logic [16:0] g, e;
        apply_reset();
        s = '{1, 2, 3, 4, 5, 6, 7, 8};
        model_block(1'b0, s, 0);
        drive_sample(s[0], 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = s[1]; bus.in_ch = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready got %b want 0", bus.in_ready); end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        for (int k = 1; k < 8; k++) drive_sample(s[k], 1'b0);
        s = '{10, 20, 30, 40, 0, 0, 0, 0};
        model_block(1'b0, s, 0); send_block(1'b0, s, -1, 1'b0);
        drain();
        vectors++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (g !== e) begin errors++; $display("[TB] FAIL bp_out got ch%0d 0x%h want ch%0d 0x%h", g[16], g[15:0], e[16], e[15:0]); end
        end
        got_q.delete(); exp_q.delete();
        vectors++;
        if (fd_count != exp_fd) begin errors++; $display("[TB] FAIL bp_frame_done got %0d want %0d", fd_count, exp_fd); end
    endtask

    task automatic test_clear();
        logic [15:0] s[8];
        logic [16:0] g, e;
        s = '{1, 2, 3, 4, 5, 6, 7, 8};
        model_block(1'b0, s, 1); send_block(1'b0, s, 5, 1'b0);
        s = '{10, 20, 30, 40, 0, 0, 0, 0};
        model_block(1'b0, s, 0); send_block(1'b0, s, -1, 1'b0);
        s = '{1, 2, 3, 4, 5, 6, 7, 8};
        model_block(1'b1, s, 0); send_block(1'b1, s, -1, 1'b0);
        s = '{0, 0, 0, 0, 50, 60, 70, 80};
        model_vld[1] = 1'b0;
        model_block(1'b0, s, 0); send_block(1'b0, s, 2, 1'b1);
        s = '{9, 9, 9, 9, 0, 0, 0, 0};
        model_block(1'b1, s, 0); send_block(1'b1, s, -1, 1'b0);
        s = '{7, 7, 7, 7, 1, 1, 1, 1};
        model_block(1'b0, s, 2); send_block(1'b0, s, 0, 1'b0);
        drain();
        vectors++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL clr_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (g !== e) begin errors++; $display("[TB] FAIL clr_out got ch%0d 0x%h want ch%0d 0x%h", g[16], g[15:0], e[16], e[15:0]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [15:0] s[8];
        logic [16:0] g, e;
        apply_reset();
        s = '{1, 2, 3, 4, 5, 6, 7, 8};
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, ref_sum(s[k], 16'h0)});
        for (int k = 0; k < 6; k++) drive_sample(s[k], 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        vectors += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid got %b want 0", bus.out_valid); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_in_ready got %b want 0", bus.in_ready); end
        if (bus.out_data !== 16'h0) begin errors++; $display("[TB] FAIL midrst_out_data got 0x%h want 0x0000", bus.out_data); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_idle got %b want 1", bus.in_ready); end
        @(posedge clk);
        #1;
        model_vld[0] = 1'b0; model_vld[1] = 1'b0; ref_sat = 1'b0;
        model_block(1'b0, s, 0); send_block(1'b0, s, -1, 1'b0);
        drain();
        vectors++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL midrst_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (g !== e) begin errors++; $display("[TB] FAIL midrst_out got ch%0d 0x%h want ch%0d 0x%h", g[16], g[15:0], e[16], e[15:0]); end
        end
        got_q.delete(); exp_q.delete();
        vectors++;
        if (fd_count != exp_fd) begin errors++; $display("[TB] FAIL midrst_frame_done got %0d want %0d", fd_count, exp_fd); end
    endtask

    task automatic test_random();
        logic [15:0] s[8];
        logic [16:0] g, e;
        logic ch, cch;
        int clr_at, mode;
        rand_bp = 1'b1;
        rand_gaps = 1'b1;
        for (int b = 0; b < 16; b++) begin
            ch = 1'($urandom);
            for (int k = 0; k < 8; k++)
                s[k] = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            clr_at = -1; mode = 0; cch = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                clr_at = $urandom_range(1, 7);
                cch = 1'($urandom);
                if (cch == ch) mode = 1;
                else model_vld[cch] = 1'b0;
            end
            model_block(ch, s, mode);
            send_block(ch, s, clr_at, cch);
        end
        drain();
        rand_bp = 1'b0;
        rand_gaps = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        vectors++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (g !== e) begin errors++; $display("[TB] FAIL rand_out got ch%0d 0x%h want ch%0d 0x%h", g[16], g[15:0], e[16], e[15:0]); end
        end
        got_q.delete(); exp_q.delete();
        vectors += 2;
        if (fd_count != exp_fd) begin errors++; $display("[TB] FAIL rand_frame_done got %0d want %0d", fd_count, exp_fd); end
        if (bus.sat_flag !== ref_sat) begin errors++; $display("[TB] FAIL rand_sat_flag got %b want %b", bus.sat_flag, ref_sat); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        bus.clr = 1'b0;
        test_reset();
        test_basic();
        test_channels();
        test_sat();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
